// File: rtl/axi_dmac_pkg.sv
// Shared types and constants for the AXI DMAC burst splitter.
// The 4 KiB guard is enabled by defining AXI_DMAC_BURST_4K_GUARD_EN.
package axi_dmac_pkg;

  localparam int BOUNDARY_4K = 4096;

  localparam int DESC_ADDR_WIDTH   = 32;
  localparam int DESC_LENGTH_WIDTH = 24;

  // Burst descriptor at the default address/length widths.
  typedef struct packed {
    logic [DESC_ADDR_WIDTH-1:0]   addr;
    logic [DESC_LENGTH_WIDTH-1:0] length;
    logic                         last;
  } burst_desc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/axi_dmac_burst_len_calc.sv
// Combinational burst length selection: min(remaining, burst limit, optional 4 KiB term).
// The 4 KiB term is compiled in only when AXI_DMAC_BURST_4K_GUARD_EN is defined.
module axi_dmac_burst_len_calc
  import axi_dmac_pkg::*;
#(
  parameter int LENGTH_WIDTH        = 24,
  parameter int MAX_BYTES_PER_BURST = 128
) (
  input  logic [11:0]             addr_low,
  input  logic [LENGTH_WIDTH:0]   rem_len,
  output logic [LENGTH_WIDTH-1:0] burst_length,
  output logic                    is_final
);

  localparam int RW = LENGTH_WIDTH + 1;
  localparam logic [RW-1:0] MAX_LEN = RW'(MAX_BYTES_PER_BURST - 1);

  logic [RW-1:0] len_min;

`ifdef AXI_DMAC_BURST_4K_GUARD_EN
  logic [RW-1:0] guard_len;
  assign guard_len = RW'(BOUNDARY_4K - 1) - RW'(addr_low);
`else
  logic addr_unused;
  assign addr_unused = ^addr_low;
`endif

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    len_min = rem_len;
    if (MAX_LEN < len_min) len_min = MAX_LEN;
`ifdef AXI_DMAC_BURST_4K_GUARD_EN
    if (guard_len < len_min) len_min = guard_len;
`endif
  end

  // len_min never exceeds the burst limit unless it equals rem_len, whose top bit is always 0.
  assign burst_length = len_min[LENGTH_WIDTH-1:0];
  assign is_final     = (len_min == rem_len);

endmodule

// File: rtl/axi_dmac_burst_splitter.sv
// Splits DMA transfer requests into bursts bounded by MAX_BYTES_PER_BURST.
// Define AXI_DMAC_BURST_4K_GUARD_EN to also keep bursts inside 4 KiB pages.
module axi_dmac_burst_splitter
  import axi_dmac_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int LENGTH_WIDTH        = 24,
  parameter int DMA_DATA_WIDTH      = 64,
  parameter int DMA_LENGTH_ALIGN    = 8,
  parameter int MAX_BYTES_PER_BURST = 128
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LENGTH_WIDTH-1:0] req_length,
  input  logic                    req_last,
  output logic                    burst_valid,
  input  logic                    burst_ready,
  output logic [ADDR_WIDTH-1:0]   burst_addr,
  output logic [LENGTH_WIDTH-1:0] burst_length,
  output logic                    burst_last,
  output logic                    busy
);

  localparam int RW = LENGTH_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ADDR_WIDTH'(DMA_DATA_WIDTH / 8 - 1);
  localparam logic [RW-1:0]         ALIGN_MASK = RW'(DMA_LENGTH_ALIGN - 1);

  split_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic                    last_q, last_d;

  logic [LENGTH_WIDTH-1:0] len_w;
  logic                    final_w;

  axi_dmac_burst_len_calc #(
    .LENGTH_WIDTH        (LENGTH_WIDTH),
    .MAX_BYTES_PER_BURST (MAX_BYTES_PER_BURST)
  ) u_len_calc (
    .addr_low     (addr_q[11:0]),
    .rem_len      (rem_q),
    .burst_length (len_w),
    .is_final     (final_w)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SPLIT;
          addr_d  = req_addr & ~BEAT_MASK;
          rem_d   = {1'b0, req_length} | ALIGN_MASK;
          last_d  = req_last;
        end
      end
      ST_SPLIT: begin
        if (burst_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(len_w) + ADDR_WIDTH'(1);
          if (final_w) begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - {1'b0, len_w} - RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

  // Descriptor outputs come straight from held registers, so they stay stable under backpressure.
  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_SPLIT);
  assign burst_valid  = busy;
  assign burst_addr   = addr_q;
  assign burst_length = len_w;
  assign burst_last   = busy && final_w && last_q;

endmodule

// File: tb/tb_axi_dmac_burst_splitter.sv
// Directed bench for axi_dmac_burst_splitter with a byte-count reference model.
// Expectations follow AXI_DMAC_BURST_4K_GUARD_EN when it is defined.
module tb_axi_dmac_burst_splitter;
  import axi_dmac_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [23:0] req_length;
  logic        req_last;
  logic        burst_valid;
  logic        burst_ready;
  logic [31:0] burst_addr;
  logic [23:0] burst_length;
  logic        burst_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int final_edge = -1;

  burst_desc_t exp_q[$];
  bit          exp_fin_q[$];
  burst_desc_t tmp_q[$];
  bit          tmp_fin_q[$];

  axi_dmac_burst_splitter dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_length   (req_length),
    .req_last     (req_last),
    .burst_valid  (burst_valid),
    .burst_ready  (burst_ready),
    .burst_addr   (burst_addr),
    .burst_length (burst_length),
    .burst_last   (burst_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: walk the request in bytes, carving chunks by the burst and page limits.
  function automatic void model_split(input logic [31:0] addr, input logic [23:0] len,
                                      input logic last);
    longint a = longint'(addr) & ~longint'(7);
    longint n = (longint'(len) | 7) + 1;
    longint c;
    burst_desc_t d;
    tmp_q.delete();
    tmp_fin_q.delete();
    while (n > 0) begin
      c = (n < 128) ? n : 128;
`ifdef AXI_DMAC_BURST_4K_GUARD_EN
      if (4096 - (a % 4096) < c) c = 4096 - (a % 4096);
`endif
      d.addr   = a[31:0];
      d.length = 24'(c - 1);
      d.last   = last && (n == c);
      tmp_q.push_back(d);
      tmp_fin_q.push_back(n == c);
      a += c;
      n -= c;
    end
  endfunction

  function automatic logic [63:0] desc(input logic [31:0] a, input logic [23:0] l,
                                       input logic lst);
    burst_desc_t d;
    d.addr = a; d.length = l; d.last = lst;
    return 64'(d);
  endfunction

  // One compare process: every valid cycle must present the model's next descriptor.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("busy/ready vs valid", {busy, req_ready}, {burst_valid, ~burst_valid});
      if (burst_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected burst", desc(burst_addr, burst_length, burst_last), 64'hDEAD);
        end else begin
          check("burst desc", desc(burst_addr, burst_length, burst_last), 64'(exp_q[0]));
          if (burst_ready) begin
            if (exp_fin_q[0]) final_edge = cyc + 1;
            void'(exp_q.pop_front());
            void'(exp_fin_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_req(input logic [31:0] a, input logic [23:0] l, input logic lst,
                          output int acc_edge);
    bit acc = 0;
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_length = l; req_last = lst;
    acc_edge = -1;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      check("request accept timeout", 0, 1);
    end else begin
      acc_edge = cyc;
      model_split(a, l, lst);
      foreach (tmp_q[i]) begin
        exp_q.push_back(tmp_q[i]);
        exp_fin_q.push_back(tmp_fin_q[i]);
      end
      check("first burst one cycle after accept", {burst_valid, busy, req_ready}, 3'b110);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, " drained"}, exp_q.size(), 0);
    check({name, " back to idle"}, {busy, req_ready}, 2'b01);
  endtask

  int e1, e2;

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_length = '0; req_last = 1'b0;
    burst_ready = 1'b1;
    #12;
    check("reset outputs", {burst_valid, busy, burst_last, burst_addr, burst_length},
          '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("ready after reset", {req_ready, busy}, 2'b10);

    // Pin the model with hand-computed tables.
    model_split(32'h1000, 24'h17F, 1'b1);
    check("model r18 count", tmp_q.size(), 3);
    check("model r18 b0", 64'(tmp_q[0]), desc(32'h1000, 24'h7F, 1'b0));
    check("model r18 b1", 64'(tmp_q[1]), desc(32'h1080, 24'h7F, 1'b0));
    check("model r18 b2", 64'(tmp_q[2]), desc(32'h1100, 24'h7F, 1'b1));
    model_split(32'h0FC0, 24'hFF, 1'b0);
`ifdef AXI_DMAC_BURST_4K_GUARD_EN
    check("model r19 count", tmp_q.size(), 3);
    check("model r19 b0", 64'(tmp_q[0]), desc(32'h0FC0, 24'h3F, 1'b0));
    check("model r19 b1", 64'(tmp_q[1]), desc(32'h1000, 24'h7F, 1'b0));
    check("model r19 b2", 64'(tmp_q[2]), desc(32'h1080, 24'h3F, 1'b0));
`else
    check("model r19 count", tmp_q.size(), 2);
    check("model r19 b0", 64'(tmp_q[0]), desc(32'h0FC0, 24'h7F, 1'b0));
    check("model r19 b1", 64'(tmp_q[1]), desc(32'h1040, 24'h7F, 1'b0));
`endif
    model_split(32'h1003, 24'h05, 1'b1);
    check("model r20 count", tmp_q.size(), 1);
    check("model r20 b0", 64'(tmp_q[0]), desc(32'h1000, 24'h07, 1'b1));

    // Basic split, 4 KiB case, alignment.
    send_req(32'h1000, 24'h17F, 1'b1, e1);
    wait_drain("basic split");
    send_req(32'h0FC0, 24'hFF, 1'b0, e1);
    wait_drain("4k guard");
    send_req(32'h1003, 24'h05, 1'b1, e1);
    wait_drain("alignment");

    // Backpressure during the second burst.
    send_req(32'h1000, 24'h17F, 1'b1, e1);
    @(posedge clk); #1;
    burst_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    burst_ready = 1'b1;
    wait_drain("backpressure");

    // Reset after the first burst.
    send_req(32'h1000, 24'h17F, 1'b1, e1);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    exp_fin_q.delete();
    #1;
    check("mid reset outputs", {burst_valid, busy, burst_last, burst_addr, burst_length},
          '0);
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("ready after mid reset", {req_ready, busy}, 2'b10);
    send_req(32'h1000, 24'h17F, 1'b1, e1);
    wait_drain("post reset split");

    // Back-to-back: second request held valid while the first splits.
    send_req(32'h1000, 24'h17F, 1'b1, e1);
    final_edge = -1;
    send_req(32'h2003, 24'h05, 1'b0, e2);
    check("b2b accept edge", e2, final_edge + 1);
    wait_drain("back-to-back");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_dmac_burst_splitter.md
AXI_DMAC_BURST_SPLITTER -- requirements
Module: axi_dmac_burst_splitter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, byte address width.
- LENGTH_WIDTH, 24, transfer length field width.
- DMA_DATA_WIDTH, 64, destination bus width in bits; power of two, 8..1024.
- DMA_LENGTH_ALIGN, 8, length granularity in bytes; power of two.
- MAX_BYTES_PER_BURST, 128, burst byte limit; power of two, at most 4096.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- resetn, in, 1, asynchronous active-low reset.
- req_valid, in, 1, transfer request valid.
- req_ready, out, 1, request accepted when high with req_valid.
- req_addr, in, ADDR_WIDTH, start byte address.
- req_length, in, LENGTH_WIDTH, transfer bytes minus 1.
- req_last, in, 1, request ends a packet.
- burst_valid, out, 1, burst descriptor valid.
- burst_ready, in, 1, downstream accepts burst.
- burst_addr, out, ADDR_WIDTH, burst start byte address.
- burst_length, out, LENGTH_WIDTH, burst bytes minus 1.
- burst_last, out, 1, final burst of a last-flagged request.
- busy, out, 1, a request is being split.

REQ-003 There SHALL be one clock, clk; reset SHALL be asynchronous and active-low on resetn.

Function
REQ-004 The FSM SHALL have two states: IDLE and SPLIT; req_ready SHALL be 1 only in IDLE.
REQ-005 On a req_valid && req_ready handshake, the block SHALL latch the following and enter SPLIT in the next cycle:
- address, with its low log2(DMA_DATA_WIDTH/8) bits forced to 0;
- remaining length, with its low log2(DMA_LENGTH_ALIGN) bits forced to 1;
- req_last.
REQ-006 In SPLIT, burst_valid SHALL be 1. Request-to-first-burst latency SHALL be one cycle.
REQ-007 burst_length SHALL be the minimum of:
- the remaining length;
- MAX_BYTES_PER_BURST-1;
- the 4 KiB boundary term when enabled (REQ-015).
REQ-008 On a burst_valid && burst_ready handshake:
- the address SHALL advance by burst_length+1;
- the remaining length SHALL decrease by burst_length+1.
REQ-009 The burst whose burst_length equals the remaining length is final; its handshake SHALL return the FSM to IDLE. req_ready SHALL be 1 in the following cycle.
REQ-010 burst_last SHALL be 1 only on the final burst, and only if the latched req_last is 1.
REQ-011 While burst_valid=1 and burst_ready=0, burst_addr, burst_length and burst_last SHALL remain stable.
REQ-012 busy SHALL equal (state==SPLIT).
REQ-013 Length arithmetic SHALL use LENGTH_WIDTH+1 bits internally. req_length of all-ones SHALL be handled without overflow.

Reset
REQ-014 When resetn is asserted, the block SHALL asynchronously:
- go to IDLE;
- drive burst_valid=0, busy=0, burst_last=0;
- clear burst_addr and burst_length to 0;
- set req_ready to 1 after deassertion.
Reset mid-SPLIT SHALL discard the remaining bursts.

Configuration
REQ-015 With the macro AXI_DMAC_BURST_4K_GUARD_EN defined:
- burst_length SHALL additionally be limited to (4096 - addr[11:0]) - 1;
- no burst SHALL cross a 4 KiB boundary.
Without the macro, only the REQ-007 limits SHALL apply.

Structure
REQ-016 The existing axi_dmac_pkg SHALL gain:
- a typedef for the burst descriptor struct (addr, length, last);
- a localparam for the 4 KiB boundary size, 4096.
REQ-017 The minimum-length computation SHALL be one combinational sub-module, axi_dmac_burst_len_calc. The FSM and registers SHALL stay in the top module.

Verification
All scenarios SHALL use default parameters, burst_ready=1 unless stated.
REQ-018 Basic split:
- Stimulus: addr 0x1000, len 0x17F, last=1.
- Response: bursts 0x1000/0x7F, 0x1080/0x7F, 0x1100/0x7F; burst_last on the third only.
REQ-019 4 KiB guard:
- Stimulus: addr 0x0FC0, len 0xFF.
- Response with macro: bursts 0x0FC0/0x3F, 0x1000/0x7F, 0x1080/0x3F.
- Response without macro: bursts 0x0FC0/0x7F, 0x1040/0x7F.
REQ-020 Alignment:
- Stimulus: addr 0x1003, len 0x05.
- Response: one burst 0x1000/0x07.
REQ-021 Backpressure:
- Stimulus: burst_ready held 0 for 5 cycles during the second burst of REQ-018.
- Response: outputs stable, no burst lost, sequence identical.
REQ-022 Reset mid-transfer:
- Stimulus: resetn pulsed low after the first burst of REQ-018.
- Response: burst_valid=0 immediately; req_ready=1 after release; a new request splits correctly.
REQ-023 Back-to-back:
- Stimulus: a second request held valid during REQ-018.
- Response: accepted the cycle after the final burst handshake; first new burst one cycle later.
